// File: rtl/conv_array_ctrl_pkg.sv
// Shared conv-layer definitions: array state codes, default sizes and
// the weight/bias ROM index helper.
package conv_array_ctrl_pkg;

   localparam int DATA_WIDTH          = 8;
   localparam int CONV_KERNEL_SIZE    = 3;
   localparam int CONV_IMAGE_SIZE     = 8;
   localparam int CONV_ARRAY_SIZE     = CONV_IMAGE_SIZE - CONV_KERNEL_SIZE + 1;
   localparam int CONV_RESULT_LATENCY = 4;
   localparam int WADDR_W             = 4;

   // State codes are seen directly by the kernel array, so they are fixed.
   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_PRELOAD = 3'd1,
      ST_ROW_0   = 3'd2,
      ST_ROW_1   = 3'd3,
      ST_ROW_2   = 3'd4,
      ST_BIAS    = 3'd5,
      ST_LOAD    = 3'd6,
      ST_IDLE    = 3'd7
   } state_t;

   // Row-major weight index inside a k x k kernel.
   function automatic logic [WADDR_W-1:0] weight_index(input int k, input int r, input int c);
      return WADDR_W'(k * r + c);
   endfunction

endpackage

// File: rtl/conv_valid_delay.sv
// Fixed-depth shift register carrying a valid flag and a row tag, used to
// align "row finished" markers with the array's output latency.
// DEPTH must be at least 2.
module conv_valid_delay #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag,
   output logic             o_pending
);

   logic [DEPTH-1:0] r_vld;
   logic [TAG_W-1:0] r_tag [DEPTH];

   // Shift valid flags and tags one stage per cycle; reset empties the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
      end else begin
         r_vld    <= {r_vld[DEPTH-2:0], i_valid};
         r_tag[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign o_valid   = r_vld[DEPTH-1];
   assign o_tag     = r_tag[DEPTH-1];
   assign o_pending = |r_vld;

endmodule

// File: rtl/conv_array_ctrl.sv
// Sequencer for a KERNEL_SIZE x KERNEL_SIZE convolution array: preloads the
// line cache, walks the kernel rows with ROM addresses, injects the bias,
// fetches the next image row, and flags finished output rows.
module conv_array_ctrl
   import conv_array_ctrl_pkg::*;
#(
   parameter int KERNEL_SIZE    = CONV_KERNEL_SIZE,
   parameter int IMAGE_SIZE     = CONV_IMAGE_SIZE,
   parameter int ARRAY_SIZE     = CONV_ARRAY_SIZE,
   parameter int RESULT_LATENCY = CONV_RESULT_LATENCY
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   output logic [2:0]         current_state,
   output logic [WADDR_W-1:0] o_weight_addr,
   output logic [2:0]         o_img_row_addr,
   output logic               o_img_row_en,
   output logic               o_result_valid,
   output logic [2:0]         o_result_row,
   output logic               o_busy,
   output logic               o_done
);

   localparam int COL_W = $clog2(KERNEL_SIZE);
   localparam int ROW_W = $clog2(ARRAY_SIZE);
   localparam int IMG_W = $clog2(IMAGE_SIZE);
   localparam logic [COL_W-1:0]   COL_LAST = COL_W'(KERNEL_SIZE - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(ARRAY_SIZE - 1);
   localparam logic [WADDR_W-1:0] W_BIAS   = WADDR_W'(KERNEL_SIZE * KERNEL_SIZE);

   state_t               r_state;
   logic [COL_W-1:0]     r_col;
   logic [ROW_W-1:0]     r_row;
   logic [WADDR_W-1:0]   r_weight_addr;
   logic [IMG_W-1:0]     r_img_row_addr;
   logic                 r_img_row_en;

   logic [2:0]           w_state_code;
   logic [1:0]           w_krow;
   logic                 w_busy;
   logic                 w_pending;
   logic                 w_res_valid;
   logic [2:0]           w_res_row;

   assign w_state_code = r_state;
   // Kernel row currently being applied (meaningful only in ROW_0..ROW_2).
   assign w_krow       = 2'(w_state_code - 3'(ST_ROW_0));
   // Busy covers the active frame plus any results still in the delay line.
   assign w_busy       = ((r_state != ST_IDLE) && (r_state != ST_INIT)) || w_pending;

   // Main sequencer: state, counters and registered address/strobe outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_INIT;
         r_col          <= '0;
         r_row          <= '0;
         r_weight_addr  <= '0;
         r_img_row_addr <= '0;
         r_img_row_en   <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: r_state <= ST_IDLE;
            ST_IDLE: begin
               if (i_start && !w_busy) begin
                  r_state        <= ST_PRELOAD;
                  r_col          <= '0;
                  r_row          <= '0;
                  r_img_row_en   <= 1'b1;
                  r_img_row_addr <= '0;
                  r_weight_addr  <= '0;
               end
            end
            ST_PRELOAD: begin
               if (r_col == COL_LAST) begin
                  r_state       <= ST_ROW_0;
                  r_col         <= '0;
                  r_img_row_en  <= 1'b0;
                  r_weight_addr <= weight_index(KERNEL_SIZE, 0, 0);
               end else begin
                  r_col          <= r_col + COL_W'(1);
                  r_img_row_addr <= r_img_row_addr + IMG_W'(1);
               end
            end
            ST_ROW_0, ST_ROW_1, ST_ROW_2: begin
               if (r_col == COL_LAST) begin
                  r_col <= '0;
                  if (r_state == ST_ROW_2) begin
                     r_state       <= ST_BIAS;
                     r_weight_addr <= W_BIAS;
                  end else begin
                     r_state       <= (r_state == ST_ROW_0) ? ST_ROW_1 : ST_ROW_2;
                     r_weight_addr <= weight_index(KERNEL_SIZE, int'(w_krow) + 1, 0);
                  end
               end else begin
                  r_col         <= r_col + COL_W'(1);
                  r_weight_addr <= weight_index(KERNEL_SIZE, int'(w_krow), int'(r_col) + 1);
               end
            end
            ST_BIAS: begin
               if (r_row < ROW_LAST) begin
                  r_state        <= ST_LOAD;
                  r_img_row_en   <= 1'b1;
                  r_img_row_addr <= IMG_W'(r_row) + IMG_W'(KERNEL_SIZE);
                  r_weight_addr  <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               r_state       <= ST_ROW_0;
               r_row         <= r_row + ROW_W'(1);
               r_img_row_en  <= 1'b0;
               r_weight_addr <= weight_index(KERNEL_SIZE, 0, 0);
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   conv_valid_delay #(
      .DEPTH (RESULT_LATENCY),
      .TAG_W (3)
   ) u_valid_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_valid   (r_state == ST_BIAS),
      .i_tag     (3'(r_row)),
      .o_valid   (w_res_valid),
      .o_tag     (w_res_row),
      .o_pending (w_pending)
   );

   assign current_state  = w_state_code;
   assign o_weight_addr  = r_weight_addr;
   assign o_img_row_addr = 3'(r_img_row_addr);
   assign o_img_row_en   = r_img_row_en;
   assign o_result_valid = w_res_valid;
   assign o_result_row   = w_res_row;
   assign o_busy         = w_busy;
   assign o_done         = w_res_valid && (w_res_row == 3'(ARRAY_SIZE - 1));

endmodule

// File: tb/tb_conv_array_ctrl.sv
// Bench for conv_array_ctrl: reset behaviour, a table-driven reference
// frame, a mid-frame reset sequence and randomized start/reset traffic
// against a frame-offset reference model.
module tb_conv_array_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_start;
   logic [2:0] current_state;
   logic [3:0] o_weight_addr;
   logic [2:0] o_img_row_addr;
   logic       o_img_row_en;
   logic       o_result_valid;
   logic [2:0] o_result_row;
   logic       o_busy;
   logic       o_done;

   conv_array_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .current_state  (current_state),
      .o_weight_addr  (o_weight_addr),
      .o_img_row_addr (o_img_row_addr),
      .o_img_row_en   (o_img_row_en),
      .o_result_valid (o_result_valid),
      .o_result_row   (o_result_row),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_err  = 0;
   int n_done = 0;

   // Behavioural 1-cycle-latency weight ROM.
   logic [7:0] rom_q = 8'd0;
   function automatic logic [7:0] rom_word(input int a);
      return 8'((a * 5 + 17) & 255);
   endfunction
   always @(posedge clk) rom_q <= rom_word(int'(o_weight_addr));

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: -1 = INIT cycle, 0 = idle and free, d>0 = cycles since start.
   int m_phase = -1;
   int m_waddr = 0;

   task automatic model_check();
      int st, wa, en, ra, rv, rr, bz, dn, d, e, r, p;
      bit cw;
      st = 7; wa = m_waddr; cw = 1'b1; en = 0; ra = -1; rv = 0; rr = -1; bz = 0; dn = 0;
      if (m_phase < 0) begin
         st = 0; wa = 0; ra = 0; rr = 0;
      end else if (m_phase > 0) begin
         d  = m_phase;
         bz = 1;
         if (d >= 17 && ((d - 17) % 11) == 0) begin
            rv = 1; rr = (d - 17) / 11; dn = (rr == 5) ? 1 : 0;
         end
         if (d <= 3) begin
            st = 1; en = 1; ra = d - 1; cw = (d == 3); wa = 0;
         end else if (d <= 68) begin
            e = d - 4; r = e / 11; p = e % 11;
            if (p < 9) begin
               st = 2 + p / 3; wa = p;
            end else if (p == 9) begin
               st = 5; wa = 9;
            end else begin
               st = 6; wa = 0; en = 1; ra = r + 3;
            end
         end else begin
            st = 7; wa = 9;
         end
      end
      chk("m_state", int'(current_state), st);
      if (cw) begin
         chk("m_weight_addr", int'(o_weight_addr), wa);
         m_waddr = wa;
      end
      chk("m_img_row_en", int'(o_img_row_en), en);
      if (ra >= 0) chk("m_img_row_addr", int'(o_img_row_addr), ra);
      chk("m_result_valid", int'(o_result_valid), rv);
      if (rr >= 0) chk("m_result_row", int'(o_result_row), rr);
      chk("m_busy", int'(o_busy), bz);
      chk("m_done", int'(o_done), dn);
   endtask

   task automatic model_advance(input bit start);
      if (m_phase < 0)        m_phase = 0;
      else if (m_phase == 0)  m_phase = start ? 1 : 0;
      else if (m_phase >= 72) m_phase = 0;
      else                    m_phase++;
   endtask

   // One cycle: check at the falling edge, drive start, advance to next falling edge.
   task automatic step(input bit start);
      model_check();
      if (o_done) n_done++;
      i_start = start;
      model_advance(start);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse issued between clock edges; outputs must clear at once.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_state", int'(current_state), 0);
      chk("rst_weight_addr", int'(o_weight_addr), 0);
      chk("rst_img_row_addr", int'(o_img_row_addr), 0);
      chk("rst_img_row_en", int'(o_img_row_en), 0);
      chk("rst_result_valid", int'(o_result_valid), 0);
      chk("rst_result_row", int'(o_result_row), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      i_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_phase = -1;
      m_waddr = 0;
   endtask

   typedef struct {
      int d; int start; int st; int wa; int en; int ra; int rv; int rr; int bz; int dn;
   } vec_t;

   function automatic vec_t mk(input int d, input int s, input int st, input int wa, input int en,
                               input int ra, input int rv, input int rr, input int bz, input int dn);
      vec_t v;
      v.d = d; v.start = s; v.st = st; v.wa = wa; v.en = en;
      v.ra = ra; v.rv = rv; v.rr = rr; v.bz = bz; v.dn = dn;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      int done_before;
      int widx;

      // Reference frame, offsets from the start cycle (-1 = don't care).
      //               d  st  state wa  en  ra  rv  rr  busy done
      tbl.push_back(mk( 0, 1, 7,  0, 0, -1, 0, -1, 0, 0));
      tbl.push_back(mk( 1, 0, 1, -1, 1,  0, 0, -1, 1, 0));
      tbl.push_back(mk( 2, 0, 1, -1, 1,  1, 0, -1, 1, 0));
      tbl.push_back(mk( 3, 0, 1,  0, 1,  2, 0, -1, 1, 0));
      tbl.push_back(mk( 4, 0, 2,  0, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk( 7, 0, 3,  3, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(10, 0, 4,  6, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(12, 0, 4,  8, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(13, 0, 5,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(14, 0, 6,  0, 1,  3, 0, -1, 1, 0));
      tbl.push_back(mk(15, 0, 2,  0, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(17, 0, 2,  2, 0, -1, 1,  0, 1, 0));
      tbl.push_back(mk(24, 0, 5,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(25, 0, 6,  0, 1,  4, 0, -1, 1, 0));
      tbl.push_back(mk(28, 0, 2,  2, 0, -1, 1,  1, 1, 0));
      tbl.push_back(mk(36, 0, 6,  0, 1,  5, 0, -1, 1, 0));
      tbl.push_back(mk(47, 0, 6,  0, 1,  6, 0, -1, 1, 0));
      tbl.push_back(mk(58, 0, 6,  0, 1,  7, 0, -1, 1, 0));
      tbl.push_back(mk(68, 0, 5,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(69, 1, 7,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(70, 1, 7,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(71, 1, 7,  9, 0, -1, 0, -1, 1, 0));
      tbl.push_back(mk(72, 1, 7,  9, 0, -1, 1,  5, 1, 1));
      tbl.push_back(mk(73, 1, 7,  9, 0, -1, 0, -1, 0, 0));
      tbl.push_back(mk(74, 0, 1, -1, 1,  0, 0, -1, 1, 0));

      // Power-on reset, then INIT for one cycle and IDLE.
      rst_n   = 1'b0;
      i_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_phase = -1;
      m_waddr = 0;
      step(1'b1);
      step(1'b0);
      step(1'b0);

      // Table-driven reference frame, including ignored start while draining.
      for (int d = 0; d <= 74; d++) begin
         widx = -1;
         foreach (tbl[k]) if (tbl[k].d == d) widx = k;
         i_start = (widx >= 0) ? tbl[widx].start[0] : 1'b0;
         if (widx >= 0) begin
            if (tbl[widx].st >= 0) chk($sformatf("tbl_state@%0d", d), int'(current_state), tbl[widx].st);
            if (tbl[widx].wa >= 0) chk($sformatf("tbl_waddr@%0d", d), int'(o_weight_addr), tbl[widx].wa);
            if (tbl[widx].en >= 0) chk($sformatf("tbl_row_en@%0d", d), int'(o_img_row_en), tbl[widx].en);
            if (tbl[widx].ra >= 0) chk($sformatf("tbl_row_addr@%0d", d), int'(o_img_row_addr), tbl[widx].ra);
            if (tbl[widx].rv >= 0) chk($sformatf("tbl_res_valid@%0d", d), int'(o_result_valid), tbl[widx].rv);
            if (tbl[widx].rr >= 0) chk($sformatf("tbl_res_row@%0d", d), int'(o_result_row), tbl[widx].rr);
            if (tbl[widx].bz >= 0) chk($sformatf("tbl_busy@%0d", d), int'(o_busy), tbl[widx].bz);
            if (tbl[widx].dn >= 0) chk($sformatf("tbl_done@%0d", d), int'(o_done), tbl[widx].dn);
         end
         if (d >= 4 && d <= 12) chk($sformatf("wseq@%0d", d), int'(o_weight_addr), d - 4);
         if (d >= 5 && d <= 15)
            chk($sformatf("rom_data@%0d", d), int'(rom_q),
                int'(rom_word(d <= 13 ? d - 5 : (d == 14 ? 9 : 0))));
         @(posedge clk);
         @(negedge clk);
      end
      m_phase = 2;
      m_waddr = 0;

      // Drain the second frame through the model.
      for (int i = 0; i < 100 && m_phase != 0; i++) step(1'b0);
      chk("drain_idle", m_phase, 0);

      // Mid-frame reset at start+30: no done, then a clean restart.
      done_before = n_done;
      step(1'b1);
      for (int i = 0; i < 29; i++) step(1'b0);
      async_reset();
      step(1'b0);
      step(1'b0);
      chk("abandoned_no_done", n_done, done_before);
      step(1'b1);
      for (int i = 0; i < 80; i++) step(1'b0);
      chk("restart_done_count", n_done, done_before + 1);

      // Randomized start requests with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) async_reset();
         else step($urandom_range(0, 5) == 0);
      end
      for (int i = 0; i < 100 && m_phase != 0; i++) step(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_array_ctrl.md
CONV_ARRAY_CTRL -- requirements
Module: conv_array_ctrl

Interface
REQ-001 The block SHALL have parameter KERNEL_SIZE, default 3, kernel edge length (KERNEL_SIZE x KERNEL_SIZE weights).
REQ-002 The block SHALL have parameter IMAGE_SIZE, default 8, input image edge length.
REQ-003 The block SHALL have parameter ARRAY_SIZE, default 6, number of output rows, equal to IMAGE_SIZE-KERNEL_SIZE+1.
REQ-004 The block SHALL have parameter RESULT_LATENCY, default 4, number of cycles from a BIAS cycle to the array's accumulator-clear cycle.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port i_start, input, 1 bit, frame start request, sampled only while o_busy=0.
REQ-008 The block SHALL have port current_state, output, 3 bits, array state code driven to the kernel array.
REQ-009 The block SHALL have port o_weight_addr, output, 4 bits, weight/bias ROM address (ROM has 1-cycle read latency).
REQ-010 The block SHALL have port o_img_row_addr, output, 3 bits, image row fetched into the line cache.
REQ-011 The block SHALL have port o_img_row_en, output, 1 bit, line-cache write strobe.
REQ-012 The block SHALL have port o_result_valid, output, 1 bit, array output bus holds a finished row.
REQ-013 The block SHALL have port o_result_row, output, 3 bits, index of the row flagged by o_result_valid.
REQ-014 The block SHALL have port o_busy, output, 1 bit, frame in progress or results still draining.
REQ-015 The block SHALL have port o_done, output, 1 bit, one-cycle pulse marking the end of the frame.

Function
REQ-016 The FSM SHALL use the state codes INIT=0, PRELOAD=1, ROW_0=2, ROW_1=3, ROW_2=4, BIAS=5, LOAD=6, IDLE=7, and current_state SHALL equal the registered FSM state.
REQ-017 The FSM SHALL go INIT->IDLE unconditionally after one cycle.
REQ-018 In IDLE, i_start=1 with o_busy=0 SHALL move the FSM to PRELOAD; otherwise the FSM SHALL stay in IDLE.
REQ-019 PRELOAD SHALL last KERNEL_SIZE cycles, with o_img_row_en=1 and o_img_row_addr=0,1,2 on successive cycles.
REQ-020 Each of ROW_0, ROW_1 and ROW_2 SHALL last KERNEL_SIZE cycles and then advance to the next state (ROW_2 advances to BIAS).
REQ-021 BIAS SHALL last 1 cycle and then go to LOAD if the output-row count is below ARRAY_SIZE-1, else to IDLE.
REQ-022 LOAD SHALL last 1 cycle, drive o_img_row_en=1 with o_img_row_addr=row+KERNEL_SIZE, increment row, and then go to ROW_0.
REQ-023 o_weight_addr SHALL be issued one cycle ahead, so the ROM data is valid in the consuming cycle: weight index k=3*r+c in ROW_r column-cycle c, and index 9 (bias) in BIAS.
REQ-024 o_weight_addr SHALL be 0 during the last PRELOAD cycle and during LOAD.
REQ-025 o_weight_addr SHALL hold its value in IDLE.
REQ-026 o_result_valid SHALL pulse exactly RESULT_LATENCY cycles after each BIAS cycle, implemented as a shift register of valid flags plus row tags.
REQ-027 o_result_row SHALL carry the row index of the BIAS cycle that produced the pulse.
REQ-028 o_busy SHALL be 1 from the PRELOAD entry cycle through the final o_result_valid cycle inclusive.
REQ-029 o_done SHALL coincide with the o_result_valid pulse for row ARRAY_SIZE-1.
REQ-030 i_start SHALL be ignored while o_busy=1, including while the FSM is in IDLE and results are still draining.
REQ-031 Frame timing SHALL be: start sampled at t0; BIAS of row r at t0+13+11r; last result_valid/done at t0+72; o_busy low at t0+73 (defaults).
REQ-032 The counters SHALL be sized by $clog2 of their maximum; row and column counters SHALL never exceed ARRAY_SIZE-1 and KERNEL_SIZE-1 respectively.

Reset
REQ-033 rst_n low SHALL immediately force: state=INIT, all counters=0, o_weight_addr=0, o_img_row_addr=0, o_img_row_en=0, o_result_valid=0, o_result_row=0, o_busy=0, o_done=0.
REQ-034 The result-valid delay line SHALL be cleared by reset.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no o_done, and the block SHALL restart via INIT->IDLE.

Structure
REQ-036 The state codes and the default sizes SHALL live in the shared conv-layer define/package, alongside DATA_WIDTH.
REQ-037 The block SHALL contain one sub-module, conv_valid_delay (parameterised-depth valid+tag shift register).

Verification
REQ-038 The bench SHALL check reset release: 1 INIT cycle, then IDLE, with all outputs 0.
REQ-039 The bench SHALL check the full frame: i_start at t0 gives PRELOAD t0+1..t0+3, row-0 BIAS at t0+13, o_result_valid at t0+17 with row 0, and done at t0+72.
REQ-040 The bench SHALL check weight addressing: the sequence in row 0 is addr 0..8 during ROW states, 9 in BIAS, and 0 in LOAD, with data matching the ROM index one cycle later.
REQ-041 The bench SHALL check that i_start held high at t0+70 (IDLE, still draining) is ignored, and that i_start at t0+73 starts a new frame.
REQ-042 The bench SHALL check that rst_n pulsed at t0+30 clears the outputs asynchronously, that o_done never fires, and that a subsequent start completes normally.
REQ-043 The bench SHALL check the LOAD fetches: o_img_row_addr = 3,4,5,6,7 with o_img_row_en pulses, and no LOAD after the row-5 BIAS.
